seq_pattern_detector: RTL and testbench

Parametrised serial bit-pattern detector, successor to the fixed 4-bit "1101" FSM detector. Pattern width is a parameter and pattern value is runtime-loadable. Overlapping vs non-overlapping matching is selectable. Input is qualified by a valid strobe, and a saturating match counter feeds status/debug logic. Sits on a serial data path behind a bit-stream source; match pulse drives downstream framing/interrupt logic.

---
 rtl/seq_det_defs.sv | 13 +
 rtl/sat_counter.sv | 36 +++
 rtl/seq_pattern_detector.sv | 85 ++++++++
 tb/tb_seq_pattern_detector.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/seq_det_defs.sv
// Shared defaults for the serial pattern detector slice.
// Default pattern, default counter width and the detector state type.
package seq_det_defs;

   localparam int         CNT_W_DEF = 8;
   localparam logic [3:0] PAT_DEF   = 4'b1101;

   typedef enum logic {
      FILLING,
      ARMED
   } det_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and sticky saturation flag.
// Ports: clk, rst_n (async low), inc, clr (wins over inc), cnt, sat.
module sat_counter
   import seq_det_defs::*;
#(
   parameter int W = CNT_W_DEF
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] cnt,
   output logic         sat
);

   localparam logic [W-1:0] MAX = '1;

   logic [W-1:0] nxt;

   assign nxt = cnt + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         sat <= 1'b0;
      end else if (clr) begin
         cnt <= '0;
         sat <= 1'b0;
      end else if (inc && cnt != MAX) begin
         cnt <= nxt;
         if (nxt == MAX)
            sat <= 1'b1;
      end
   end

endmodule

// File: rtl/seq_pattern_detector.sv
// Serial bit-pattern detector: loadable pattern, optional overlap, valid-qualified input.
// Ports: clk, rst_n, in_valid, in, overlap_en, pat_load, pat_in, cnt_clr, out, match_cnt, cnt_sat.
module seq_pattern_detector
   import seq_det_defs::*;
#(
   parameter int               PAT_W   = 4,
   parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(PAT_DEF),
   parameter int               CNT_W   = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic             in,
   input  logic             overlap_en,
   input  logic             pat_load,
   input  logic [PAT_W-1:0] pat_in,
   input  logic             cnt_clr,
   output logic             out,
   output logic [CNT_W-1:0] match_cnt,
   output logic             cnt_sat
);

   localparam int             FW   = $clog2(PAT_W + 1);
   localparam logic [FW-1:0] FULL = FW'(PAT_W);
   localparam logic [FW-1:0] LAST = FW'(PAT_W - 1);

   logic [PAT_W-1:0] pattern, pattern_d;
   logic [PAT_W-1:0] history, history_d;
   logic [PAT_W-1:0] hist_sh;
   logic [FW-1:0]    fill, fill_d;
   logic             out_d;
   logic             hit;
   det_state_e       state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pattern <= RST_PAT;
         history <= '0;
         fill    <= '0;
         out     <= 1'b0;
      end else begin
         pattern <= pattern_d;
         history <= history_d;
         fill    <= fill_d;
         out     <= out_d;
      end
   end

   always_comb begin
      pattern_d = pattern;
      history_d = history;
      fill_d    = fill;
      out_d     = 1'b0;
      hit       = 1'b0;
      hist_sh   = {history[PAT_W-2:0], in};
      state     = (fill == FULL) ? ARMED : FILLING;
      if (pat_load) begin
         pattern_d = pat_in;
         fill_d    = '0;
      end else if (in_valid) begin
         history_d = hist_sh;
         // fill>=PAT_W-1 means this bit completes a full window
         hit = (hist_sh == pattern) && (fill >= LAST);
         out_d = hit;
         if (hit && !overlap_en)
            fill_d = '0;
         else if (state == ARMED)
            fill_d = FULL;
         else
            fill_d = fill + 1'b1;
      end
   end

   sat_counter #(
      .W (CNT_W)
   ) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (out_d),
      .clr   (cnt_clr),
      .cnt   (match_cnt),
      .sat   (cnt_sat)
   );

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Bench for seq_pattern_detector: directed scenarios plus random stream vs queue model.
// Two instances share stimulus: default CNT_W=8 and CNT_W=2 for saturation.
module tb_seq_pattern_detector;

   localparam int PAT_W = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       vld, din, ovl, pld, cclr;
   logic [3:0] pin;
   logic       out1, out2, sat1, sat2;
   logic [7:0] cnt1;
   logic [1:0] cnt2;

   int tests = 0;
   int fails = 0;
   int npulse;

   bit         hq[$];
   logic [3:0] mpat;
   int         c1, c2;
   logic       m_hit;

   always #5 clk = ~clk;

   seq_pattern_detector dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(vld), .in(din),
      .overlap_en(ovl), .pat_load(pld), .pat_in(pin), .cnt_clr(cclr),
      .out(out1), .match_cnt(cnt1), .cnt_sat(sat1)
   );

   seq_pattern_detector #(.CNT_W(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(vld), .in(din),
      .overlap_en(ovl), .pat_load(pld), .pat_in(pin), .cnt_clr(cclr),
      .out(out2), .match_cnt(cnt2), .cnt_sat(sat2)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      hq.delete();
      mpat = 4'b1101;
      c1 = 0;
      c2 = 0;
   endtask

   task automatic check_all(input logic eo);
      chk("out1", {31'b0, out1}, {31'b0, eo});
      chk("out2", {31'b0, out2}, {31'b0, eo});
      chk("cnt1", {24'b0, cnt1}, c1);
      chk("sat1", {31'b0, sat1}, {31'b0, c1 == 255});
      chk("cnt2", {30'b0, cnt2}, c2);
      chk("sat2", {31'b0, sat2}, {31'b0, c2 == 3});
   endtask

   task automatic step(input logic v, input logic b, input logic ov,
                       input logic ld, input logic [3:0] pi,
                       input logic clr);
      logic [3:0] w;
      vld = v; din = b; ovl = ov; pld = ld; pin = pi; cclr = clr;
      @(posedge clk);
      m_hit = 1'b0;
      if (ld) begin
         mpat = pi;
         hq.delete();
      end else if (v) begin
         hq.push_back(b);
         if (hq.size() > PAT_W) void'(hq.pop_front());
         if (hq.size() == PAT_W) begin
            w = '0;
            for (int i = 0; i < PAT_W; i++) w = {w[2:0], hq[i]};
            m_hit = (w == mpat);
         end
         if (m_hit && !ov) hq.delete();
      end
      if (clr) begin
         c1 = 0;
         c2 = 0;
      end else if (m_hit) begin
         if (c1 < 255) c1++;
         if (c2 < 3) c2++;
      end
      #1;
      if (out1) npulse++;
      check_all(m_hit);
   endtask

   task automatic bits(input logic [15:0] v, input int n, input logic ov);
      for (int i = n - 1; i >= 0; i--) step(1'b1, v[i], ov, 1'b0, 4'h0, 1'b0);
   endtask

   initial begin
      rst_n = 1'b0;
      vld = 0; din = 0; ovl = 1; pld = 0; pin = 0; cclr = 0;
      model_reset();
      #12;
      check_all(1'b0);
      rst_n = 1'b1;
      @(negedge clk);

      // default pattern 1101
      bits(16'b1101, 4, 1'b1);
      step(0, 0, 1, 0, 0, 0);

      // overlapping versus restart-after-match
      step(0, 0, 1, 0, 0, 1);
      npulse = 0;
      bits(16'b1101101, 7, 1'b1);
      chk("ovl_pulses", npulse, 2);
      step(1, 1, 1, 1, 4'b1101, 1);
      npulse = 0;
      bits(16'b1101101, 7, 1'b0);
      chk("novl_pulses", npulse, 1);

      // gap in valid keeps partial match
      step(0, 0, 1, 1, 4'b1101, 0);
      npulse = 0;
      bits(16'b11, 2, 1'b1);
      for (int i = 0; i < 3; i++) step(0, i[0], 1, 0, 0, 0);
      bits(16'b01, 2, 1'b1);
      chk("gap_pulses", npulse, 1);

      // runtime pattern load
      bits(16'b110, 3, 1'b1);
      step(1, 1, 1, 1, 4'b0000, 0);
      npulse = 0;
      bits(16'b00000, 5, 1'b1);
      chk("load_ovl", npulse, 2);
      step(0, 0, 1, 1, 4'b0000, 0);
      npulse = 0;
      bits(16'b00000, 5, 1'b0);
      chk("load_novl", npulse, 1);

      // saturation on the 2-bit counter instance
      step(0, 0, 1, 1, 4'b1101, 1);
      for (int k = 0; k < 4; k++) bits(16'b1101, 4, 1'b0);
      step(0, 0, 1, 0, 0, 1);

      // clear versus simultaneous match
      bits(16'b110, 3, 1'b0);
      step(1, 1, 0, 0, 0, 1);

      // async reset mid-stream
      bits(16'b110, 3, 1'b1);
      bits(16'b1101, 4, 1'b1);
      bits(16'b110, 3, 1'b1);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_all(1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      step(1, 1, 1, 0, 0, 0);

      // random stream
      for (int i = 0; i < 800; i++) begin
         step($urandom_range(0, 3) != 0, 1'($urandom),
              $urandom_range(0, 7) != 0,
              $urandom_range(0, 39) == 0, 4'($urandom),
              $urandom_range(0, 59) == 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
